spi_slave_regbank: RTL and testbench
====================================

// Module: spi_slave_regbank
// PURPOSE
//  Parametrised SPI-slave register bank. Successor to the fixed 4+1-channel slave: NUM_CH channel words, double-buffered outputs, a command register and an error/status register.
//  Sits between the board SPI master and the beam-steering channel word outputs (gain/phase/RxTx/spare fields are packed by downstream logic).
//  Frames run back-to-back while chip-select stays low.
// PARAMETERS
//  NUM_CH       5        channel registers, addresses 0..NUM_CH-1
//  ADDR_W       7        address bits per frame; must satisfy 2**ADDR_W > max(NUM_CH-1, ID_ADDR, STAT_ADDR, CMD_ADDR)
//  DATA_W       16       data bits per frame (>= 8)
//  PRODUCT_ID   16'h0500 read-only ID value, zero-extended or truncated to DATA_W
//  ID_ADDR      5        product-ID address (read-only)
//  STAT_ADDR    6        status address
//  CMD_ADDR     7        command address
//  DEFAULT_VAL  0        reset/load-default value of every channel register
//  AUTO_UPDATE  1        1: active outputs follow shadow on each write; 0: only on CMD update
// PORTS
//  SlaveClock       in   1              SPI clock = block clock; all logic on rising edge
//  ResetButton      in   1              asynchronous, active-low reset
//  SlaveChipSelect  in   1              active-low frame enable
//  SlaveDataIn      in   1              MOSI, sampled on rising edge
//  SlaveDataOut     out  1              MISO, registered; changes after rising edge
//  ChannelWords     out  NUM_CH*DATA_W  active registers; channel i at [i*DATA_W +: DATA_W]
//  UpdatePulse      out  1              1-cycle pulse when any active register is written
//  ErrorCount       out  8              saturating protocol-error counter
// BEHAVIOUR
//  Reset: async, active-low.
//   - Shadow and active registers = DEFAULT_VAL.
//   - Bit counter, shift registers, SlaveDataOut, UpdatePulse and ErrorCount = 0.
//  Frame layout: edge k=0 mode bit (1 write, 0 read), then k=1..ADDR_W address (MSB first), then k=ADDR_W+1..ADDR_W+DATA_W data (MSB first).
//   - k counts rising edges with SlaveChipSelect=0.
//   - After k=ADDR_W+DATA_W, the next low-CS edge is k=0 of a new frame (continuous mode).
//  Read:
//   - At edge k=ADDR_W, the read register is selected from {addr shift reg, SlaveDataIn} and loaded into the MISO shift reg.
//   - SlaveDataOut = read-data MSB after that edge; the master samples it at edge k=ADDR_W+1. One bit shifts per edge.
//   - Read map: channel i returns its shadow; ID_ADDR returns PRODUCT_ID; STAT_ADDR returns {ErrorCount, zeros}, ErrorCount in MSBs; CMD_ADDR and unmapped addresses return 0.
//   - No side effects.
//  SlaveDataOut = 0 outside the read data phase and whenever CS=1.
//  Write commit: at edge k=ADDR_W+DATA_W, word = {data shift reg, SlaveDataIn}.
//   - Channel i: shadow <= word; if AUTO_UPDATE, active <= word on the same edge.
//   - CMD_ADDR bit0 = load defaults: shadow and active <= DEFAULT_VAL.
//   - CMD_ADDR bit1 = update: active <= shadow for all channels. bit0 has priority when both bits are set.
//   - STAT_ADDR: clears ErrorCount; not an error.
//   - ID_ADDR or unmapped address: ignored, ErrorCount+1.
//  UpdatePulse is high for the cycle after any commit that changed an active register (value compare not required).
//  Abort: CS rises with 0<k<=ADDR_W+DATA_W, i.e. a partial frame.
//   - Frame discarded, no register changes, ErrorCount+1, k <= 0.
//   - CS high at k=0 is idle, not an error.
//  ErrorCount saturates at 255. When an error and a STAT clear coincide, the clear wins.
//  Reset mid-frame: frame discarded, no commit.
// TESTING
//  1. Reset, then write 0xABCD to addr 0 and read addr 0 -> reads 0xABCD; ChannelWords[15:0]=0xABCD; UpdatePulse high for 1 cycle.
//  2. Read ID_ADDR -> 0x0500. Write 0x1234 to ID_ADDR -> ID unchanged, ErrorCount=1. Read STAT -> 0x0100. Write STAT -> ErrorCount=0.
//  3. AUTO_UPDATE=0: write 0x89AB to ch1 -> readback 0x89AB, ChannelWords ch1 still DEFAULT. Write CMD=0x0002 -> ch1 active=0x89AB, UpdatePulse.
//  4. CS held low: 4 back-to-back writes 0xFFFF to ch0..3, then 5 reads of ch0..4 -> 0xFFFF x4, ch4 unchanged. No idle cycles between frames.
//  5. Drop CS after 10 data bits of a write to ch2 (old value 0x0246) -> ch2 stays 0x0246, ErrorCount+1. The next full frame works.
//  6. Write CMD=0x0003 after ch0..4 = 0xFFFF -> all shadow and active = DEFAULT_VAL. Assert reset mid-read -> SlaveDataOut=0 immediately.

Source files
------------

// File: rtl/spi_slave_regbank_if.sv
// spi_slave_regbank_if: SPI pins plus channel word, update and error outputs of the register bank
interface spi_slave_regbank_if #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 16
);
  logic SlaveChipSelect;
  logic SlaveDataIn;
  logic SlaveDataOut;
  logic [NUM_CH*DATA_W-1:0] ChannelWords;
  logic UpdatePulse;
  logic [7:0] ErrorCount;
  modport master(output SlaveChipSelect, SlaveDataIn, input SlaveDataOut, ChannelWords, UpdatePulse, ErrorCount);
  modport slave(input SlaveChipSelect, SlaveDataIn, output SlaveDataOut, ChannelWords, UpdatePulse, ErrorCount);
endinterface

// File: rtl/spi_slave_regbank.sv
// spi_slave_regbank: SPI-slave register bank with shadow/active channel words, command and status registers
module spi_slave_regbank #(
  parameter int NUM_CH = 5,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter logic [15:0] PRODUCT_ID = 16'h0500,
  parameter int ID_ADDR = 5,
  parameter int STAT_ADDR = 6,
  parameter int CMD_ADDR = 7,
  parameter logic [DATA_W-1:0] DEFAULT_VAL = '0,
  parameter bit AUTO_UPDATE = 1'b1
) (
  input logic SlaveClock,
  input logic ResetButton,
  spi_slave_regbank_if.slave bus
);
  localparam int LAST = ADDR_W + DATA_W;
  localparam int CW = $clog2(LAST + 1);
  localparam logic [CW-1:0] K_ADDR = CW'(ADDR_W);
  localparam logic [CW-1:0] K_LAST = CW'(LAST);
  localparam logic [ADDR_W-1:0] A_ID = ADDR_W'(ID_ADDR);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(STAT_ADDR);
  localparam logic [ADDR_W-1:0] A_CMD = ADDR_W'(CMD_ADDR);
  logic cs, din, mode, dout, upd;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] addr, raddr;
  logic [DATA_W-2:0] data_sr, miso_sr;
  logic [DATA_W-1:0] rdata, word;
  logic [DATA_W-1:0] shadow [NUM_CH];
  logic [DATA_W-1:0] active [NUM_CH];
  logic [7:0] err;
  logic commit, ch_hit, wr_ch, wr_stat, wr_cmd, wr_bad, abort;
  assign cs = bus.SlaveChipSelect;
  assign din = bus.SlaveDataIn;
  assign raddr = {addr[ADDR_W-2:0], din};
  assign word = {data_sr, din};
  assign commit = !cs && cnt == K_LAST && mode;
  assign ch_hit = {1'b0, addr} < (ADDR_W+1)'(NUM_CH);
  assign wr_ch = commit && ch_hit;
  assign wr_stat = commit && addr == A_STAT;
  assign wr_cmd = commit && addr == A_CMD;
  assign wr_bad = commit && !ch_hit && addr != A_STAT && addr != A_CMD;
  assign abort = cs && cnt != '0;
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) rdata = raddr == ADDR_W'(i) ? shadow[i] : rdata;
    rdata = raddr == A_ID ? DATA_W'(PRODUCT_ID) : rdata;
    rdata = raddr == A_STAT ? DATA_W'(err) << (DATA_W - 8) : rdata;
  end
  // MISO shifts zeros in behind the read word, so it idles low outside the data phase
  always_ff @(posedge SlaveClock or negedge ResetButton)
    if (!ResetButton) begin
      cnt <= '0;
      mode <= 1'b0;
      addr <= '0;
      data_sr <= '0;
      {dout, miso_sr} <= '0;
    end else if (cs) begin
      cnt <= '0;
      {dout, miso_sr} <= '0;
    end else begin
      cnt <= cnt == K_LAST ? '0 : cnt + CW'(1);
      if (cnt == '0) mode <= din;
      if (cnt != '0 && cnt <= K_ADDR) addr <= raddr;
      data_sr <= {data_sr[DATA_W-3:0], din};
      {dout, miso_sr} <= cnt == K_ADDR && !mode ? rdata : {miso_sr, 1'b0};
    end
  always_ff @(posedge SlaveClock or negedge ResetButton)
    if (!ResetButton) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= DEFAULT_VAL;
        active[i] <= DEFAULT_VAL;
      end
      err <= '0;
      upd <= 1'b0;
    end else begin
      upd <= (wr_ch && AUTO_UPDATE) || (wr_cmd && (word[0] || word[1]));
      for (int i = 0; i < NUM_CH; i++)
        if (wr_cmd && word[0]) begin
          shadow[i] <= DEFAULT_VAL;
          active[i] <= DEFAULT_VAL;
        end else if (wr_cmd && word[1]) active[i] <= shadow[i];
        else if (wr_ch && addr == ADDR_W'(i)) begin
          shadow[i] <= word;
          if (AUTO_UPDATE) active[i] <= word;
        end
      if (wr_stat) err <= '0;
      else if ((wr_bad || abort) && err != 8'hFF) err <= err + 8'd1;
    end
  for (genvar g = 0; g < NUM_CH; g++) assign bus.ChannelWords[g*DATA_W +: DATA_W] = active[g];
  assign bus.SlaveDataOut = dout;
  assign bus.UpdatePulse = upd;
  assign bus.ErrorCount = err;
endmodule

// File: tb/tb_spi_slave_regbank.sv
// tb_spi_slave_regbank: directed checks on two banks (auto-update and manual-update) sharing one SPI bus
module tb_spi_slave_regbank;
  logic clk = 1'b0, rst_n = 1'b0, cs = 1'b1, din = 1'b0;
  logic [15:0] qa, qm;
  int pass_cnt = 0, total = 0;
  always #5 clk = ~clk;
  spi_slave_regbank_if #(.NUM_CH(5), .DATA_W(16)) ia ();
  spi_slave_regbank_if #(.NUM_CH(5), .DATA_W(16)) im ();
  assign ia.SlaveChipSelect = cs;
  assign ia.SlaveDataIn = din;
  assign im.SlaveChipSelect = cs;
  assign im.SlaveDataIn = din;
  spi_slave_regbank #(.AUTO_UPDATE(1'b1)) u_a (.SlaveClock(clk), .ResetButton(rst_n), .bus(ia.slave));
  spi_slave_regbank #(.AUTO_UPDATE(1'b0)) u_m (.SlaveClock(clk), .ResetButton(rst_n), .bus(im.slave));

  // drives n bits of a frame; MISO of both banks is sampled before each data edge
  task automatic frame(input logic w, input logic [6:0] a, input logic [15:0] d, input int n,
                       output logic [15:0] ra, output logic [15:0] rm);
    logic [23:0] f;
    f = {w, a, d};
    ra = '0;
    rm = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k >= 8) begin
        ra = {ra[14:0], ia.SlaveDataOut};
        rm = {rm[14:0], im.SlaveDataOut};
      end
      cs = 1'b0;
      din = f[23-k];
    end
  endtask
  task automatic release_cs;
    @(negedge clk);
    cs = 1'b1;
    din = 1'b0;
  endtask
  task automatic wr(input logic [6:0] a, input logic [15:0] d);
    frame(1'b1, a, d, 24, qa, qm);
    release_cs();
  endtask
  task automatic rd(input logic [6:0] a);
    frame(1'b0, a, 16'h0000, 24, qa, qm);
    release_cs();
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (ia.ChannelWords !== 80'h0) $display("FAIL reset_words: got %h expected 0", ia.ChannelWords); else pass_cnt++;
    total++; if (ia.ErrorCount !== 8'd0) $display("FAIL reset_err: got %0d expected 0", ia.ErrorCount); else pass_cnt++;
    total++; if (ia.SlaveDataOut !== 1'b0) $display("FAIL reset_miso: got %b expected 0", ia.SlaveDataOut); else pass_cnt++;
    total++; if (ia.UpdatePulse !== 1'b0) $display("FAIL reset_upd: got %b expected 0", ia.UpdatePulse); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    wr(7'd0, 16'hABCD);
    total++; if (ia.UpdatePulse !== 1'b1) $display("FAIL wr0_upd_high: got %b expected 1", ia.UpdatePulse); else pass_cnt++;
    total++; if (ia.ChannelWords[15:0] !== 16'hABCD) $display("FAIL wr0_active: got %h expected abcd", ia.ChannelWords[15:0]); else pass_cnt++;
    @(negedge clk);
    total++; if (ia.UpdatePulse !== 1'b0) $display("FAIL wr0_upd_low: got %b expected 0", ia.UpdatePulse); else pass_cnt++;
    rd(7'd0);
    total++; if (qa !== 16'hABCD) $display("FAIL rd0: got %h expected abcd", qa); else pass_cnt++;
  endtask

  task automatic test_id_stat;
    rd(7'd5);
    total++; if (qa !== 16'h0500) $display("FAIL rd_id: got %h expected 0500", qa); else pass_cnt++;
    wr(7'd5, 16'h1234);
    total++; if (ia.ErrorCount !== 8'd1) $display("FAIL err_id_write: got %0d expected 1", ia.ErrorCount); else pass_cnt++;
    total++; if (ia.UpdatePulse !== 1'b0) $display("FAIL upd_id_write: got %b expected 0", ia.UpdatePulse); else pass_cnt++;
    rd(7'd5);
    total++; if (qa !== 16'h0500) $display("FAIL rd_id_after: got %h expected 0500", qa); else pass_cnt++;
    rd(7'd6);
    total++; if (qa !== 16'h0100) $display("FAIL rd_stat: got %h expected 0100", qa); else pass_cnt++;
    wr(7'd6, 16'h0000);
    total++; if (ia.ErrorCount !== 8'd0) $display("FAIL stat_clear: got %0d expected 0", ia.ErrorCount); else pass_cnt++;
    rd(7'd100);
    total++; if (qa !== 16'h0000) $display("FAIL rd_unmapped: got %h expected 0000", qa); else pass_cnt++;
  endtask

  task automatic test_manual_update;
    wr(7'd1, 16'h89AB);
    total++; if (im.ChannelWords[31:16] !== 16'h0000) $display("FAIL man_ch1_held: got %h expected 0000", im.ChannelWords[31:16]); else pass_cnt++;
    total++; if (im.UpdatePulse !== 1'b0) $display("FAIL man_no_upd: got %b expected 0", im.UpdatePulse); else pass_cnt++;
    total++; if (ia.ChannelWords[31:16] !== 16'h89AB) $display("FAIL auto_ch1: got %h expected 89ab", ia.ChannelWords[31:16]); else pass_cnt++;
    rd(7'd1);
    total++; if (qm !== 16'h89AB) $display("FAIL man_rd1: got %h expected 89ab", qm); else pass_cnt++;
    wr(7'd7, 16'h0002);
    total++; if (im.ChannelWords[31:16] !== 16'h89AB) $display("FAIL man_update: got %h expected 89ab", im.ChannelWords[31:16]); else pass_cnt++;
    total++; if (im.UpdatePulse !== 1'b1) $display("FAIL man_upd_pulse: got %b expected 1", im.UpdatePulse); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) frame(1'b1, 7'(i), 16'hFFFF, 24, qa, qm);
    for (int i = 0; i < 5; i++) begin
      frame(1'b0, 7'(i), 16'h0000, 24, qa, qm);
      if (i < 4) begin
        total++; if (qa !== 16'hFFFF) $display("FAIL b2b_rd%0d: got %h expected ffff", i, qa); else pass_cnt++;
      end else begin
        total++; if (qa !== 16'h0000) $display("FAIL b2b_rd4: got %h expected 0000", qa); else pass_cnt++;
      end
    end
    release_cs();
    total++; if (ia.ChannelWords !== {16'h0000, {4{16'hFFFF}}}) $display("FAIL b2b_active: got %h expected 0000ffffffffffffffff", ia.ChannelWords); else pass_cnt++;
    total++; if (ia.ErrorCount !== 8'd0) $display("FAIL b2b_err: got %0d expected 0", ia.ErrorCount); else pass_cnt++;
  endtask

  task automatic test_abort;
    wr(7'd2, 16'h0246);
    frame(1'b1, 7'd2, 16'h1357, 18, qa, qm);
    release_cs();
    @(negedge clk);
    total++; if (ia.ErrorCount !== 8'd1) $display("FAIL abort_err: got %0d expected 1", ia.ErrorCount); else pass_cnt++;
    total++; if (ia.ChannelWords[47:32] !== 16'h0246) $display("FAIL abort_active: got %h expected 0246", ia.ChannelWords[47:32]); else pass_cnt++;
    rd(7'd2);
    total++; if (qa !== 16'h0246) $display("FAIL abort_shadow: got %h expected 0246", qa); else pass_cnt++;
    wr(7'd3, 16'h1111);
    total++; if (ia.ChannelWords[63:48] !== 16'h1111) $display("FAIL after_abort_wr: got %h expected 1111", ia.ChannelWords[63:48]); else pass_cnt++;
  endtask

  task automatic test_saturate;
    wr(7'd6, 16'h0000);
    for (int i = 0; i < 254; i++) begin
      @(negedge clk); cs = 1'b0;
      @(negedge clk); cs = 1'b1;
    end
    @(negedge clk);
    total++; if (ia.ErrorCount !== 8'd254) $display("FAIL err_254: got %0d expected 254", ia.ErrorCount); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); cs = 1'b0;
      @(negedge clk); cs = 1'b1;
    end
    @(negedge clk);
    total++; if (ia.ErrorCount !== 8'd255) $display("FAIL err_sat: got %0d expected 255", ia.ErrorCount); else pass_cnt++;
    rd(7'd6);
    total++; if (qa !== 16'hFF00) $display("FAIL rd_stat_sat: got %h expected ff00", qa); else pass_cnt++;
    wr(7'd6, 16'h0000);
    total++; if (ia.ErrorCount !== 8'd0) $display("FAIL sat_clear: got %0d expected 0", ia.ErrorCount); else pass_cnt++;
  endtask

  task automatic test_load_default;
    for (int i = 0; i < 5; i++) frame(1'b1, 7'(i), 16'hFFFF, 24, qa, qm);
    release_cs();
    total++; if (ia.ChannelWords !== {5{16'hFFFF}}) $display("FAIL all_ffff: got %h expected all ffff", ia.ChannelWords); else pass_cnt++;
    wr(7'd7, 16'h0003);
    total++; if (ia.ChannelWords !== 80'h0) $display("FAIL dflt_auto: got %h expected 0", ia.ChannelWords); else pass_cnt++;
    total++; if (im.ChannelWords !== 80'h0) $display("FAIL dflt_man: got %h expected 0", im.ChannelWords); else pass_cnt++;
    total++; if (ia.UpdatePulse !== 1'b1) $display("FAIL dflt_upd: got %b expected 1", ia.UpdatePulse); else pass_cnt++;
    rd(7'd3);
    total++; if (qm !== 16'h0000) $display("FAIL dflt_shadow: got %h expected 0000", qm); else pass_cnt++;
  endtask

  task automatic test_reset_mid_read;
    wr(7'd0, 16'hFFFF);
    frame(1'b0, 7'd0, 16'h0000, 12, qa, qm);
    @(negedge clk);
    total++; if (ia.SlaveDataOut !== 1'b1) $display("FAIL mid_read_miso: got %b expected 1", ia.SlaveDataOut); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (ia.SlaveDataOut !== 1'b0) $display("FAIL rst_miso: got %b expected 0", ia.SlaveDataOut); else pass_cnt++;
    total++; if (ia.ChannelWords !== 80'h0) $display("FAIL rst_words: got %h expected 0", ia.ChannelWords); else pass_cnt++;
    cs = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    rd(7'd0);
    total++; if (qa !== 16'h0000) $display("FAIL rst_shadow: got %h expected 0000", qa); else pass_cnt++;
    total++; if (ia.ErrorCount !== 8'd0) $display("FAIL rst_err: got %0d expected 0", ia.ErrorCount); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_id_stat();
    test_manual_update();
    test_back_to_back();
    test_abort();
    test_saturate();
    test_load_default();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
